// File: rtl/p3_pll_ctrl.sv
// p3_pll_ctrl: ProASIC3 PLL power-up, lock qualification, system-reset hold and bounded-retry recovery
module p3_pll_ctrl #(
    parameter int CNT_W         = 16,
    parameter int PD_CYCLES     = 50,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int RST_HOLD      = 16,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       pll_lock,
    output logic       pll_pwrdn_n,
    output logic       locked,
    output logic       sys_rst,
    output logic       lost_lock,
    output logic       fault,
    output logic [3:0] retries,
    output logic [2:0] state
);
    localparam logic [2:0] S_OFF    = 3'd0;
    localparam logic [2:0] S_PD     = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_STABLE = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    localparam logic [CNT_W-1:0] PD_LAST = CNT_W'(PD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD    = CNT_W'(RST_HOLD);
    localparam logic [3:0]       MAXR    = 4'(MAX_RETRIES);

    logic [1:0]       sync_q;
    logic             lock_s;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retries_q, retries_d, retries_inc;
    logic             pll_pwrdn_n_q, pll_pwrdn_n_d;
    logic             locked_q, locked_d;
    logic             sys_rst_q, sys_rst_d;
    logic             lost_lock_q, lost_lock_d;
    logic             fault_q, fault_d;

    assign lock_s      = sync_q[1];
    assign retries_inc = retries_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        retries_d   = retries_q;
        lost_lock_d = 1'b0;
        if (!enable) begin
            state_d   = S_OFF;
            cnt_d     = '0;
            retries_d = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d = S_PD;
                    cnt_d   = '0;
                end
                S_PD: begin
                    state_d = (cnt_q == PD_LAST) ? S_WAIT : S_PD;
                    cnt_d   = (cnt_q == PD_LAST) ? '0 : cnt_q + 1'b1;
                end
                S_WAIT: begin
                    if (lock_s) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TO_LAST) begin
                        retries_d = retries_inc;
                        state_d   = (retries_inc == MAXR) ? S_FAULT : S_PD;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end else if (cnt_q == ST_LAST) begin
                        state_d   = S_RUN;
                        cnt_d     = '0;
                        retries_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_d     = S_PD;
                        cnt_d       = '0;
                        lost_lock_d = 1'b1;
                    end else begin
                        cnt_d = (cnt_q >= HOLD) ? cnt_q : cnt_q + 1'b1;
                    end
                end
                S_FAULT: cnt_d = '0;
                default: begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
        // Outputs are decoded from the next state so they register in step with state_q.
        pll_pwrdn_n_d = (state_d == S_WAIT) || (state_d == S_STABLE) || (state_d == S_RUN);
        locked_d      = (state_d == S_RUN);
        sys_rst_d     = !((state_d == S_RUN) && (cnt_d >= HOLD));
        fault_d       = (state_d == S_FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q        <= 2'b00;
            state_q       <= S_OFF;
            cnt_q         <= '0;
            retries_q     <= '0;
            pll_pwrdn_n_q <= 1'b0;
            locked_q      <= 1'b0;
            sys_rst_q     <= 1'b1;
            lost_lock_q   <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            sync_q        <= {sync_q[0], pll_lock};
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retries_q     <= retries_d;
            pll_pwrdn_n_q <= pll_pwrdn_n_d;
            locked_q      <= locked_d;
            sys_rst_q     <= sys_rst_d;
            lost_lock_q   <= lost_lock_d;
            fault_q       <= fault_d;
        end
    end

    assign pll_pwrdn_n = pll_pwrdn_n_q;
    assign locked      = locked_q;
    assign sys_rst     = sys_rst_q;
    assign lost_lock   = lost_lock_q;
    assign fault       = fault_q;
    assign retries     = retries_q;
    assign state       = state_q;
endmodule

// File: tb/tb_p3_pll_ctrl.sv
// tb_p3_pll_ctrl: directed scenarios plus random lock/enable traffic against a phase/age reference model
module tb_p3_pll_ctrl;
    localparam int PD   = 4;
    localparam int TO   = 20;
    localparam int ST   = 8;
    localparam int HOLD = 3;
    localparam int MAXR = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_pwrdn_n, locked, sys_rst, lost_lock, fault;
    logic [3:0] retries;
    logic [2:0] state;

    int total = 0;
    int bad = 0;

    int m_phase = 0;
    int m_age = 0;
    int m_ret = 0;
    bit m_lost = 1'b0;
    bit s1 = 1'b0;
    bit s2 = 1'b0;

    always #10 clk = ~clk;

    p3_pll_ctrl #(
        .CNT_W(16), .PD_CYCLES(PD), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(ST),
        .RST_HOLD(HOLD), .MAX_RETRIES(MAXR)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .pll_lock(pll_lock),
        .pll_pwrdn_n(pll_pwrdn_n), .locked(locked), .sys_rst(sys_rst),
        .lost_lock(lost_lock), .fault(fault), .retries(retries), .state(state)
    );

    task automatic go(input int p);
        m_phase = p;
        m_age   = 0;
    endtask

    task automatic model_edge();
        bit ls;
        if (rst) begin
            m_phase = 0; m_age = 0; m_ret = 0; m_lost = 0; s1 = 0; s2 = 0;
            return;
        end
        ls = s2; s2 = s1; s1 = pll_lock;
        m_lost = 0;
        if (!enable) begin
            go(0);
            m_ret = 0;
            return;
        end
        case (m_phase)
            0: go(1);
            1: if (m_age + 1 == PD) go(2); else m_age++;
            2: if (ls) go(3);
               else if (m_age + 1 == TO) begin m_ret++; go(m_ret == MAXR ? 5 : 1); end
               else m_age++;
            3: if (!ls) go(2);
               else if (m_age + 1 == ST) begin m_ret = 0; go(4); end
               else m_age++;
            4: if (!ls) begin m_lost = 1; go(1); end else m_age++;
            default: ;
        endcase
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("state", 4'(state), 4'(m_phase));
        chk("pwrdn_n", 4'(pll_pwrdn_n), 4'(m_phase >= 2 && m_phase <= 4));
        chk("locked", 4'(locked), 4'(m_phase == 4));
        chk("sys_rst", 4'(sys_rst), 4'(!(m_phase == 4 && m_age >= HOLD)));
        chk("lost_lock", 4'(lost_lock), 4'(m_lost));
        chk("fault", 4'(fault), 4'(m_phase == 5));
        chk("retries", retries, 4'(m_ret));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_phase(input int p, input int a, input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            step();
            ok = (m_phase == p && m_age == a);
        end
        total++;
        assert (ok) else begin
            bad++;
            $error("FAIL wait_%0d_%0d observed=timeout expected=reached", p, a);
        end
    endtask

    initial begin
        rst = 1'b1;
        run(3);
        chk("rst_state", 4'(state), 4'd0);
        chk("rst_sysrst", 4'(sys_rst), 4'd1);
        rst = 1'b0; enable = 1'b1; pll_lock = 1'b1;
        run(25);
        chk("s1_state", 4'(state), 4'd4);
        chk("s1_sysrst", 4'(sys_rst), 4'd0);
        pll_lock = 1'b0;
        run(2);
        step();
        chk("s4_lost", 4'(lost_lock), 4'd1);
        chk("s4_state", 4'(state), 4'd1);
        pll_lock = 1'b1;
        run(30);
        chk("s4_rerun", 4'(state), 4'd4);
        chk("s4_retries", retries, 4'd0);
        enable = 1'b0; pll_lock = 1'b0;
        step();
        enable = 1'b1;
        run(60);
        chk("s2_fault", 4'(fault), 4'd1);
        chk("s2_retries", retries, 4'd2);
        chk("s2_pwrdn", 4'(pll_pwrdn_n), 4'd0);
        enable = 1'b0;
        step();
        chk("s2_off", 4'(state), 4'd0);
        chk("s2_clear", 4'(fault), 4'd0);
        enable = 1'b1; pll_lock = 1'b1;
        wait_phase(3, 5, 40);
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        run(30);
        chk("s3_run", 4'(state), 4'd4);
        enable = 1'b0; pll_lock = 1'b0;
        step();
        enable = 1'b1;
        wait_phase(2, 17, 40);
        pll_lock = 1'b1;
        run(2);
        step();
        chk("s5_state", 4'(state), 4'd3);
        chk("s5_retries", retries, 4'd0);
        run(2);
        enable = 1'b0;
        step();
        chk("s6_off", 4'(state), 4'd0);
        chk("s6_pwrdn", 4'(pll_pwrdn_n), 4'd0);
        chk("s6_sysrst", 4'(sys_rst), 4'd1);
        enable = 1'b1;
        run(30);
        chk("s6_run", 4'(state), 4'd4);
        rst = 1'b1;
        step();
        chk("s6_rst_state", 4'(state), 4'd0);
        chk("s6_rst_locked", 4'(locked), 4'd0);
        chk("s6_rst_sysrst", 4'(sys_rst), 4'd1);
        rst = 1'b0;
        for (int seg = 0; seg < 6; seg++) begin
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, (seg % 2 == 1) ? 3 : 63) == 0) pll_lock = ~pll_lock;
                enable = ($urandom_range(0, 199) != 0);
                rst = ($urandom_range(0, 499) == 0);
                step();
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
